uart_cmd_parser: RTL and testbench

Serial command front end for the NIC test top level. It consumes bytes from the UART receiver (`rx` byte plus toggle strobe) and assembles them into a command character plus up to 16 hex digits of argument (`$`, `<cmd>`, `<hex...>`, `+`). On `+` it presents a held command request to the top-level state machine, which dispatches it to `ether_ctrl`, `ether_tx` or `ether_rx`. Every accepted byte is echoed to the transmit path.

---
 rtl/uart_cmd_parser.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles "$ <cmd> <hex...> +" byte streams from the UART
// receiver into a held command request, echoing every accepted byte.
module uart_cmd_parser (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_rch,
  input  logic        rx_rcv,
  input  logic        cmd_ack,
  output logic        cmd_req,
  output logic [7:0]  cmd,
  output logic [63:0] data,
  output logic [4:0]  ndigits,
  output logic [7:0]  echo_ch,
  output logic        echo_stb,
  output logic [2:0]  err
);

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_DATA = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_PLUS   = 8'h2B;

  // err bit positions: {overrun, bad_digit, nocmd}
  localparam int ERR_NOCMD   = 0;
  localparam int ERR_BADDIG  = 1;
  localparam int ERR_OVERRUN = 2;

  state_t      state_q, state_d;
  logic        rx_rcv_old_q;
  logic        cmd_req_q, cmd_req_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [63:0] data_q, data_d;
  logic [4:0]  ndigits_q, ndigits_d;
  logic [7:0]  echo_ch_q, echo_ch_d;
  logic        echo_stb_q, echo_stb_d;
  logic [2:0]  err_q, err_d;

  logic        new_byte;
  logic [3:0]  nib;
  logic        nib_ok;

  // A byte is present whenever the toggle differs from its last sampled value.
  assign new_byte = (rx_rcv != rx_rcv_old_q);

  // Hex digit decode; anything that is not a hex digit maps to zero.
  always_comb begin
    nib    = 4'd0;
    nib_ok = 1'b0;
    if (rx_rch >= 8'h30 && rx_rch <= 8'h39) begin
      nib    = rx_rch[3:0];
      nib_ok = 1'b1;
    end else if ((rx_rch >= 8'h61 && rx_rch <= 8'h66) ||
                 (rx_rch >= 8'h41 && rx_rch <= 8'h46)) begin
      nib    = 4'(rx_rch[3:0] + 4'd9);
      nib_ok = 1'b1;
    end
  end

  // Next-state and next-output logic for the parser.
  always_comb begin
    state_d    = state_q;
    cmd_req_d  = cmd_req_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    ndigits_d  = ndigits_q;
    echo_ch_d  = echo_ch_q;
    echo_stb_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_CMD: begin
        if (new_byte) begin
          echo_stb_d = 1'b1;
          echo_ch_d  = rx_rch;
          if (rx_rch == CH_DOLLAR) begin
            cmd_d     = 8'd0;
            data_d    = 64'd0;
            ndigits_d = 5'd0;
            err_d     = 3'd0;
          end else if (rx_rch == CH_PLUS) begin
            err_d[ERR_NOCMD] = 1'b1;
          end else begin
            cmd_d     = rx_rch;
            data_d    = 64'd0;
            ndigits_d = 5'd0;
            state_d   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (new_byte) begin
          echo_stb_d = 1'b1;
          echo_ch_d  = rx_rch;
          if (rx_rch == CH_DOLLAR) begin
            cmd_d     = 8'd0;
            data_d    = 64'd0;
            ndigits_d = 5'd0;
            err_d     = 3'd0;
            state_d   = S_CMD;
          end else if (rx_rch == CH_PLUS) begin
            cmd_req_d = 1'b1;
            state_d   = S_PEND;
          end else begin
            // Oldest nibble falls off the top once 16 digits are held.
            data_d = {data_q[59:0], nib};
            if (ndigits_q < 5'd16) begin
              ndigits_d = ndigits_q + 5'd1;
            end
            if (!nib_ok) begin
              err_d[ERR_BADDIG] = 1'b1;
            end
          end
        end
      end

      S_PEND: begin
        // Bytes arriving while a command is pending are lost, never echoed.
        if (new_byte) begin
          err_d[ERR_OVERRUN] = 1'b1;
        end
        if (cmd_ack) begin
          cmd_req_d = 1'b0;
          state_d   = S_CMD;
        end
      end

      default: begin
        state_d   = S_CMD;
        cmd_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; the toggle history follows rx_rcv even in reset.
  always_ff @(posedge clk) begin
    rx_rcv_old_q <= rx_rcv;
    if (reset) begin
      state_q    <= S_CMD;
      cmd_req_q  <= 1'b0;
      cmd_q      <= 8'd0;
      data_q     <= 64'd0;
      ndigits_q  <= 5'd0;
      echo_ch_q  <= 8'd0;
      echo_stb_q <= 1'b0;
      err_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      ndigits_q  <= ndigits_d;
      echo_ch_q  <= echo_ch_d;
      echo_stb_q <= echo_stb_d;
      err_q      <= err_d;
    end
  end

  assign cmd_req  = cmd_req_q;
  assign cmd      = cmd_q;
  assign data     = data_q;
  assign ndigits  = ndigits_q;
  assign echo_ch  = echo_ch_q;
  assign echo_stb = echo_stb_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed stimulus with an echo scoreboard queue.
module tb_uart_cmd_parser;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_rch;
  logic        rx_rcv;
  logic        cmd_ack;
  logic        cmd_req;
  logic [7:0]  cmd;
  logic [63:0] data;
  logic [4:0]  ndigits;
  logic [7:0]  echo_ch;
  logic        echo_stb;
  logic [2:0]  err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] echo_q[$];

  uart_cmd_parser dut (
    .clk      (clk),
    .reset    (reset),
    .rx_rch   (rx_rch),
    .rx_rcv   (rx_rcv),
    .cmd_ack  (cmd_ack),
    .cmd_req  (cmd_req),
    .cmd      (cmd),
    .data     (data),
    .ndigits  (ndigits),
    .echo_ch  (echo_ch),
    .echo_stb (echo_stb),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Echo scoreboard: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (echo_stb === 1'b1) begin
      checks++;
      if (echo_q.size() == 0) begin
        assert (0) else begin
          failures++;
          $error("FAIL echo_unexpected observed=%h expected=none", echo_ch);
        end
      end else begin
        logic [7:0] exp_b;
        exp_b = echo_q.pop_front();
        assert (echo_ch === exp_b) else begin
          failures++;
          $error("FAIL echo_ch observed=%h expected=%h", echo_ch, exp_b);
        end
        $display("echo byte=%h expected=%h", echo_ch, exp_b);
      end
    end
  end

  // Drive one byte; check that the echo strobe appears exactly one edge later.
  task automatic send(input logic [7:0] b, input logic exp_echo);
    @(posedge clk); #1;
    rx_rch = b;
    rx_rcv = ~rx_rcv;
    if (exp_echo) echo_q.push_back(b);
    @(posedge clk); #1;
    chk("echo_latency", {63'd0, echo_stb}, {63'd0, exp_echo});
    repeat (2) @(posedge clk);
  endtask

  task automatic send_str(input string s, input logic exp_echo);
    for (int i = 0; i < s.len(); i++) send(s[i], exp_echo);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    cmd_ack = 1'b1;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
  endtask

  task automatic chk_cmd(input string tag, input logic req, input logic [7:0] c,
                         input logic [63:0] d, input logic [4:0] n, input logic [2:0] e);
    $display("%s: req=%0b cmd=%h data=%h ndigits=%0d err=%b", tag, cmd_req, cmd, data, ndigits, err);
    chk({tag, "_req"},  {63'd0, cmd_req}, {63'd0, req});
    chk({tag, "_cmd"},  {56'd0, cmd},     {56'd0, c});
    chk({tag, "_data"}, data,             d);
    chk({tag, "_nd"},   {59'd0, ndigits}, {59'd0, n});
    chk({tag, "_err"},  {61'd0, err},     {61'd0, e});
  endtask

  initial begin
    reset   = 1'b1;
    rx_rch  = 8'h00;
    rx_rcv  = 1'b0;
    cmd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cmd("reset", 1'b0, 8'h00, 64'h0, 5'd0, 3'b000);
    chk("reset_echo_stb", {63'd0, echo_stb}, 64'd0);
    chk("reset_echo_ch", {56'd0, echo_ch}, 64'd0);
    reset = 1'b0;

    // Basic command
    send_str("$L001F+", 1'b1);
    chk_cmd("basic", 1'b1, 8'h4C, 64'h1F, 5'd4, 3'b000);
    ack_pulse();
    chk_cmd("basic_ack", 1'b0, 8'h4C, 64'h1F, 5'd4, 3'b000);

    // Bad digit handling, mixed case
    send_str("XaBz+", 1'b1);
    chk_cmd("baddig", 1'b1, 8'h58, 64'hAB0, 5'd3, 3'b010);
    ack_pulse();

    // Saturating digit count, oldest digits shifted out
    send_str("$T0123456789abcdef12+", 1'b1);
    chk_cmd("long", 1'b1, 8'h54, 64'h23456789ABCDEF12, 5'd16, 3'b000);
    ack_pulse();

    // '+' with no command
    send_str("$+", 1'b1);
    chk_cmd("nocmd", 1'b0, 8'h00, 64'h0, 5'd0, 3'b001);
    send_str("G+", 1'b1);
    chk_cmd("nodata", 1'b1, 8'h47, 64'h0, 5'd0, 3'b001);

    // Overrun while pending; bytes dropped, no echo
    send_str("5$", 1'b0);
    chk_cmd("overrun", 1'b1, 8'h47, 64'h0, 5'd0, 3'b101);
    @(posedge clk); #1;
    cmd_ack = 1'b1;
    rx_rch  = 8'h41;
    rx_rcv  = ~rx_rcv;
    @(posedge clk); #1;
    cmd_ack = 1'b0;
    chk("ack_byte_no_echo", {63'd0, echo_stb}, 64'd0);
    repeat (2) @(posedge clk); #1;
    chk_cmd("ack_byte", 1'b0, 8'h47, 64'h0, 5'd0, 3'b101);
    send("$", 1'b1);
    chk_cmd("clear", 1'b0, 8'h00, 64'h0, 5'd0, 3'b000);

    // Ignored ack outside S_PEND, then reset mid-command with a toggle in reset
    send_str("Q1", 1'b1);
    ack_pulse();
    chk_cmd("stray_ack", 1'b0, 8'h51, 64'h1, 5'd1, 3'b000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rx_rch = 8'h2B;
    rx_rcv = ~rx_rcv;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_cmd("mid_reset", 1'b0, 8'h00, 64'h0, 5'd0, 3'b000);
    chk("mid_reset_echo", {63'd0, echo_stb}, 64'd0);
    send("R", 1'b1);
    chk_cmd("after_reset", 1'b0, 8'h52, 64'h0, 5'd0, 3'b000);
    send("+", 1'b1);
    chk_cmd("after_reset_go", 1'b1, 8'h52, 64'h0, 5'd0, 3'b000);

    repeat (3) @(posedge clk); #1;
    chk("echo_queue_empty", 64'(echo_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
